// File: rtl/btn_pkt_pkg.sv
// Shared constants and types for the button command packet encoder and parser.
package btn_pkt_pkg;

    // ASCII characters used in the controller packet stream
    localparam logic [7:0] CH_BANG = 8'h21;
    localparam logic [7:0] CH_B    = 8'h42;
    localparam logic [7:0] CH_b    = 8'h62;
    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_ONE  = 8'h31;

    // Packet lengths in bytes, with and without the trailing checksum
    localparam int unsigned PKT_LEN_CRC    = 5;
    localparam int unsigned PKT_LEN_NO_CRC = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

endpackage

// File: rtl/button_packet_encoder.sv
// Serialises one button event into '!', command, digit, state[, checksum] bytes
// over a valid/ready byte interface toward a UART transmitter.
module button_packet_encoder
    import btn_pkt_pkg::*;
#(
    parameter logic [7:0]  CMD_CHAR   = CH_B,
    parameter bit          SEND_CRC   = 1'b1,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] key_val,
    input  logic       press,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_IDX = SEND_CRC ? 3'(PKT_LEN_CRC - 1) : 3'(PKT_LEN_NO_CRC - 1);
    localparam int unsigned CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic [2:0]       key_q, key_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             done_q, done_d;
    logic [7:0]       byte_cur;
    logic             xfer;

    // Byte multiplexer: select the packet byte for the current index
    always_comb begin
        byte_cur = 8'h00;
        case (idx_q)
            3'd0:    byte_cur = CH_BANG;
            3'd1:    byte_cur = CMD_CHAR;
            3'd2:    byte_cur = CH_ONE + {5'd0, key_q};
            3'd3:    byte_cur = press_q ? CH_ONE : CH_ZERO;
            default: byte_cur = ~sum_q;
        endcase
    end

    assign xfer = (state_q == SEND) && tx_ready;

    // Next-state logic: request latch, byte sequencing, checksum and gap counting
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        key_d   = key_q;
        press_d = press_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    key_d   = key_val;
                    press_d = press;
                    idx_d   = 3'd0;
                    sum_d   = 8'h00;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    sum_d = sum_q + byte_cur;
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        idx_d   = 3'd0;
                        gap_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any packet in flight without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            sum_q   <= 8'h00;
            key_q   <= 3'd0;
            press_q <= 1'b0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            key_q   <= key_d;
            press_q <= press_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode straight from state so reset clears them immediately
    always_comb begin
        req_ready = (state_q == IDLE);
        tx_valid  = (state_q == SEND);
        tx_data   = (state_q == SEND) ? byte_cur : 8'h00;
        busy      = (state_q != IDLE);
        done      = done_q;
    end

endmodule

// File: tb/tb_button_packet_encoder.sv
// Bench for button_packet_encoder: two configurations checked against a packet model.
module tb_button_packet_encoder;
    import btn_pkt_pkg::*;

    localparam int unsigned GAP_A = 16;

    logic clk = 1'b0;
    logic [1:0]      rst, req_valid, press, tx_ready;
    logic [1:0][2:0] key_val;
    wire  [1:0]      req_ready, tx_valid, busy, done;
    wire  [1:0][7:0] tx_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // Instance 0: 'B', checksum on, 16-cycle gap
    button_packet_encoder #(.CMD_CHAR(CH_B), .SEND_CRC(1'b1), .GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .key_val(key_val[0]), .press(press[0]), .tx_data(tx_data[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .busy(busy[0]), .done(done[0])
    );

    // Instance 1: 'b', no checksum, no gap
    button_packet_encoder #(.CMD_CHAR(CH_b), .SEND_CRC(1'b0), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .key_val(key_val[1]), .press(press[1]), .tx_data(tx_data[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference packet: plain ASCII arithmetic, checksum = 255 - (sum mod 256)
    task automatic build(input int d, input int key, input bit p);
        int s;
        exp_q = {};
        exp_q.push_back(8'h21);
        exp_q.push_back((d == 0) ? 8'h42 : 8'h62);
        exp_q.push_back(8'(49 + key));
        exp_q.push_back(p ? 8'h31 : 8'h30);
        s = 0;
        foreach (exp_q[i]) s += int'(exp_q[i]);
        if (d == 0) exp_q.push_back(8'(255 - (s % 256)));
    endtask

    task automatic check_reset_state(input int d);
        chk1("rst_req_ready", req_ready[d], 1'b1);
        chk1("rst_tx_valid", tx_valid[d], 1'b0);
        chk8("rst_tx_data", tx_data[d], 8'h00);
        chk1("rst_busy", busy[d], 1'b0);
        chk1("rst_done", done[d], 1'b0);
    endtask

    // Called at a negedge; returns at the negedge where the first byte is visible
    task automatic send_req(input int d, input logic [2:0] k, input logic p);
        int n = 0;
        while (req_ready[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("req_ready_wait", req_ready[d], 1'b1);
        key_val[d]   = k;
        press[d]     = p;
        req_valid[d] = 1'b1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        key_val[d]   = 3'($urandom);
        press[d]     = 1'($urandom);
    endtask

    // Drains exp_q from the DUT; returns at the negedge after the final transfer
    task automatic collect(input int d, input bit bp, input bit poke);
        int idx = 0;
        int cyc = 0;
        bit stall = 1'b0;
        logic [7:0] held = 8'h00;
        while (idx < exp_q.size() && cyc < 400) begin
            chk1("tx_valid", tx_valid[d], 1'b1);
            chk1("busy_send", busy[d], 1'b1);
            chk1("req_ready_send", req_ready[d], 1'b0);
            chk1("done_early", done[d], 1'b0);
            if (stall) chk8("hold", tx_data[d], held);
            tx_ready[d]  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            req_valid[d] = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (tx_valid[d] && tx_ready[d]) begin
                chk8($sformatf("byte%0d", idx), tx_data[d], exp_q[idx]);
                idx++;
                stall = 1'b0;
            end else begin
                stall = tx_valid[d];
                held  = tx_data[d];
            end
            @(negedge clk);
            cyc++;
        end
        req_valid[d] = 1'b0;
        chk_int("bytes_sent", idx, exp_q.size());
        if (!bp) chk_int("cycles", cyc, exp_q.size());
        chk1("done", done[d], 1'b1);
        chk1("tx_valid_after", tx_valid[d], 1'b0);
    endtask

    // Starts in the done cycle; requests poked during the gap must be ignored
    task automatic gap_check(input int d, input int gap);
        for (int i = 0; i < gap - 1; i++) begin
            @(negedge clk);
            chk1("gap_done", done[d], 1'b0);
            chk1("gap_req_ready", req_ready[d], 1'b0);
            chk1("gap_busy", busy[d], 1'b1);
            chk1("gap_tx_valid", tx_valid[d], 1'b0);
            req_valid[d] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        chk1("gap_end_req_ready", req_ready[d], 1'b1);
        chk1("gap_end_busy", busy[d], 1'b0);
        chk1("gap_end_tx_valid", tx_valid[d], 1'b0);
    endtask

    initial begin
        int k;
        bit p;
        rst       = 2'b11;
        req_valid = 2'b00;
        press     = 2'b00;
        tx_ready  = 2'b00;
        key_val   = '0;
        @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        rst = 2'b00;
        @(negedge clk);

        // Button 3 press, tight timing, then full gap with ignored requests
        tx_ready[0] = 1'b1;
        build(0, 2, 1'b1);
        send_req(0, 3'd2, 1'b1);
        collect(0, 1'b0, 1'b0);
        chk1("gap_entry_ready", req_ready[0], 1'b0);
        gap_check(0, GAP_A);

        // Release on the no-checksum, no-gap instance, then back-to-back request
        tx_ready[1] = 1'b1;
        build(1, 4, 1'b0);
        send_req(1, 3'd4, 1'b0);
        collect(1, 1'b0, 1'b0);
        chk1("b2b_req_ready", req_ready[1], 1'b1);
        k = int'($urandom_range(0, 7));
        p = 1'($urandom);
        key_val[1]   = 3'(k);
        press[1]     = p;
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        build(1, k, p);
        collect(1, 1'b0, 1'b0);
        chk1("b2b_ready_after", req_ready[1], 1'b1);

        // Key 7 press under random backpressure with requests poked during SEND
        build(0, 6, 1'b1);
        send_req(0, 3'd6, 1'b1);
        collect(0, 1'b1, 1'b1);
        gap_check(0, GAP_A);
        @(negedge clk);
        chk1("no_queued_packet", tx_valid[0], 1'b0);
        k = int'($urandom_range(0, 7));
        p = 1'($urandom);
        build(0, k, p);
        send_req(0, 3'(k), p);
        collect(0, 1'b0, 1'b0);

        // Reset after two bytes have transferred aborts the packet
        tx_ready[0] = 1'b1;
        send_req(0, 3'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk8("pre_rst_byte", tx_data[0], 8'h36);
        rst[0] = 1'b1;
        #2;
        chk1("async_rst_tx_valid", tx_valid[0], 1'b0);
        chk8("async_rst_tx_data", tx_data[0], 8'h00);
        chk1("async_rst_busy", busy[0], 1'b0);
        @(negedge clk);
        rst[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("post_rst_done", done[0], 1'b0);
            chk1("post_rst_tx_valid", tx_valid[0], 1'b0);
        end
        build(0, 3, 1'b1);
        send_req(0, 3'd3, 1'b1);
        collect(0, 1'b0, 1'b0);

        // Random events on both instances with random backpressure
        for (int n = 0; n < 4; n++) begin
            k = int'($urandom_range(0, 7));
            p = 1'($urandom);
            build(1, k, p);
            send_req(1, 3'(k), p);
            collect(1, 1'b1, 1'b1);
        end
        for (int n = 0; n < 3; n++) begin
            k = int'($urandom_range(0, 7));
            p = 1'($urandom);
            build(0, k, p);
            send_req(0, 3'(k), p);
            collect(0, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
